// File: rtl/fp_align_pkg.sv
// Shared types and sizing for the float operand-alignment stage.
// Sizes here follow the default single-precision format.
package fp_align_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DONE
  } state_t;

  localparam int EXP_W_D = 8;
  localparam int MAN_W_D = 23;
  localparam int W       = 1 + EXP_W_D + MAN_W_D;
  localparam int EXT_W   = MAN_W_D + 4;
  localparam int MAX_SH  = MAN_W_D + 3;
  localparam int CNT_W   = $clog2(MAX_SH + 1);

  // Denormals share the exponent of the smallest normal.
  function automatic logic [31:0] eff_exp(input logic [31:0] e);
    return (e == 32'd0) ? 32'd1 : e;
  endfunction

endpackage

// File: rtl/fp_align_seq_if.sv
// Operand/result handshake bundle for the alignment stage.
interface fp_align_seq_if import fp_align_pkg::*; #(
  parameter int EXP_W = EXP_W_D,
  parameter int MAN_W = MAN_W_D
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   x;
  logic [EXP_W+MAN_W:0]   y;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   big;
  logic [MAN_W+3:0]       small_ext;
  logic [EXP_W-1:0]       dif;
  logic                   swap;
  logic                   eff_sub;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, big, small_ext, dif, swap, eff_sub
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, big, small_ext, dif, swap, eff_sub
  );
endinterface

// File: rtl/fp_mag_compare.sv
// Orders two packed floats by full magnitude and derives the exponent gap
// plus the smaller operand's hidden bit and mantissa.
module fp_mag_compare import fp_align_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  output logic [EXP_W+MAN_W:0] big,
  output logic [MAN_W-1:0]     sml_man,
  output logic                 sml_hid,
  output logic                 swap,
  output logic [EXP_W-1:0]     dif
);
  logic [EXP_W+MAN_W:0] sml;

  always_comb begin
    // {exp, man} compares as an unsigned integer; ties keep x as big.
    swap    = (y[EXP_W+MAN_W-1:0] > x[EXP_W+MAN_W-1:0]);
    big     = swap ? y : x;
    sml     = swap ? x : y;
    sml_man = sml[MAN_W-1:0];
    sml_hid = |sml[MAN_W +: EXP_W];
    dif     = EXP_W'(eff_exp(32'(big[MAN_W +: EXP_W])))
            - EXP_W'(eff_exp(32'(sml[MAN_W +: EXP_W])));
  end
endmodule

// File: rtl/fp_align_seq.sv
// Multi-cycle alignment: swaps operands by magnitude, then right-shifts the
// smaller significand up to STEP bits per cycle, folding lost bits into sticky.
module fp_align_seq import fp_align_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEP  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_align_seq_if.slave  bus
);
  localparam int OW = 1 + EXP_W + MAN_W;
  localparam int XW = MAN_W + 4;
  localparam int MS = MAN_W + 3;
  localparam int CW = $clog2(MS + 1);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [OW-1:0]   big_reg, big_next;
  logic [XW-1:0]   ext_reg, ext_next;
  logic [EXP_W-1:0] dif_reg, dif_next;
  logic            swap_reg, swap_next;
  logic            eff_reg, eff_next;

  logic [OW-1:0]    cmp_big;
  logic [MAN_W-1:0] cmp_man;
  logic             cmp_hid;
  logic             cmp_swap;
  logic [EXP_W-1:0] cmp_dif;
  logic [CW-1:0]    dc;
  logic [CW-1:0]    sh;
  logic [XW-1:0]    mask;
  logic [XW-1:0]    shifted;

  fp_mag_compare #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (
    .x       (bus.x),
    .y       (bus.y),
    .big     (cmp_big),
    .sml_man (cmp_man),
    .sml_hid (cmp_hid),
    .swap    (cmp_swap),
    .dif     (cmp_dif)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      big_reg   <= '0;
      ext_reg   <= '0;
      dif_reg   <= '0;
      swap_reg  <= 1'b0;
      eff_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      big_reg   <= big_next;
      ext_reg   <= ext_next;
      dif_reg   <= dif_next;
      swap_reg  <= swap_next;
      eff_reg   <= eff_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    big_next   = big_reg;
    ext_next   = ext_reg;
    dif_next   = dif_reg;
    swap_next  = swap_reg;
    eff_next   = eff_reg;

    // Shifting past MS only re-ORs the hidden bit into sticky, so clamp.
    dc = (32'(cmp_dif) > 32'(MS)) ? CW'(MS) : CW'(cmp_dif);

    sh      = (cnt_reg > STEP_C) ? STEP_C : cnt_reg;
    mask    = ~({XW{1'b1}} << sh);
    shifted = (ext_reg >> sh) | {{(XW-1){1'b0}}, |(ext_reg & mask)};

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          big_next   = cmp_big;
          ext_next   = {cmp_hid, cmp_man, 3'b000};
          dif_next   = cmp_dif;
          swap_next  = cmp_swap;
          eff_next   = bus.x[OW-1] ^ bus.y[OW-1];
          cnt_next   = dc;
          state_next = (dc == '0) ? DONE : ALIGN;
        end
      end
      ALIGN: begin
        ext_next = shifted;
        cnt_next = cnt_reg - sh;
        if (cnt_reg == sh) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.big       = big_reg;
  assign bus.small_ext = ext_reg;
  assign bus.dif       = dif_reg;
  assign bus.swap      = swap_reg;
  assign bus.eff_sub   = eff_reg;
endmodule

// File: doc/fp_align_seq.md
# fp_align_seq

Sequential, parametrised operand-alignment stage for the IEEE-754 adder datapath. It takes two packed floats over a valid/ready handshake and orders them by full magnitude (exponent, then mantissa). It computes the effective exponent difference and right-shifts the smaller significand STEP bits per cycle, producing guard/round/sticky bits. It sits between the operand registers and the significand adder/normaliser, replacing the single-cycle exponent-only swap/difference logic.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, stored mantissa width (W = 1+EXP_W+MAN_W)
- STEP, 4, max shift per ALIGN cycle (1..MAN_W+3)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands x, y valid
- in_ready  out  1  block can accept (high in IDLE)
- x, y  in  W  packed operands {sign, exp, man}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- big  out  W  larger-magnitude operand, unmodified
- small_ext  out  MAN_W+4  aligned smaller significand {hidden, man, G, R, S}
- dif  out  EXP_W  unclamped effective exponent difference
- swap  out  1  1 = y was larger
- eff_sub  out  1  x.sign XOR y.sign

## Operation
- Effective exponent: exp==0 -> 1, else exp. Hidden bit = (exp != 0).
- Magnitude compare on {exp, man} unsigned. If |y| > |x|, then big=y and swap=1. Ties give big=x, swap=0.
- dif = eff_exp(big) - eff_exp(small), always >= 0.
- Shift count dc = min(dif, MAN_W+3). MAN_W+3 is exact: at that count the hidden bit reaches S, and any further shift only keeps it sticky.
- small_ext initial value = {hidden, man, 3'b000}.
- Each shift: shift right by s = min(remaining, STEP). S_new = S_old OR (OR of the s bits shifted out).
- No NaN/Inf/zero special-casing. big is passed through; downstream handles specials.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, register swapped operands, dif, eff_sub, remaining=dc. Go to DONE if dc==0, else ALIGN.
  - ALIGN: shift by min(remaining, STEP) and decrement remaining. Go to DONE when it reaches 0.
  - DONE: out_valid=1, all outputs held stable. On out_ready, go to IDLE.
- No overlap: in_ready=0 in ALIGN and DONE. There is no same-cycle DONE->accept bypass.

## Timing
- Reset (async): state=IDLE. out_valid, big, small_ext, dif, swap, eff_sub all 0.
- in_ready is 1 whenever state is IDLE, including during reset. Transfers while rst_n=0 are ignored.
- Latency: with k = ceil(dc/STEP), out_valid rises k+1 cycles after the accept edge. For dc=0, out_valid is high in the cycle immediately after the accept.
- Worst case at the defaults: dc=26, k=7, so out_valid rises 8 cycles after accept.
- Back-to-back throughput: one result per k+2 cycles with out_ready tied high.
- Reset asserted mid-ALIGN or mid-DONE aborts the operation immediately. No partial result is emitted after release.
- out_ready outside DONE is ignored.

## Structure
- Package fp_align_pkg holds:
  - state enum {IDLE, ALIGN, DONE}
  - localparams W, EXT_W = MAN_W+4, MAX_SH = MAN_W+3, CNT_W = $clog2(MAX_SH+1)
  - function eff_exp
- One combinational sub-module, fp_mag_compare: swap, dif, swap flag and hidden bits, parametrised on EXP_W/MAN_W.
- The FSM, shift register and counter live in fp_align_seq.

## Test plan
- x=0x40400000, y=0x3F800000 -> big=x, swap=0, dif=1, small_ext=0x2000000, out_valid 2 cycles after accept.
- x=0x3F800000, y=0x3FC00000 -> big=y, swap=1, dif=0, small_ext=0x4000000, out_valid 1 cycle after accept. Repeat with x=y=0x3F800000 -> swap=0.
- x=0x4B800000, y=0x3F800001 -> dif=24, k=6, small_ext=0x0000005 (G=1, S=1). Sweep STEP in {1,4,26}; the result must be identical with latency ceil(24/STEP)+1.
- x=0x7F000000, y=0x3F800000 -> dif=127, clamp 26, small_ext=0x0000001, out_valid 8 cycles after accept (STEP=4).
- Denormal: x=0x00800000, y=0x80000001 -> big=x, dif=0, small_ext=0x0000008, eff_sub=1.
- Protocol:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0.
  - Pulse rst_n low mid-ALIGN: all outputs 0 at once and in_ready=1 after release.
  - A new accept afterwards completes correctly.
